// File: rtl/trig_event_buffer.sv
// Trigger event buffer: captures strobed trigger events into a small FIFO and streams each as a byte frame.
// Define TRIG_EVENT_BUFFER_CRC_EN to append a CRC-8 (poly 0x07, init 0x00) byte before the end marker.
module trig_event_buffer #(
    parameter int N_CH     = 24,
    parameter int DEPTH    = 4,
    parameter int ID_W     = 16,
    parameter int CYC_W    = 48,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                   sampling_clk,
    input  logic                   reset,
    input  logic                   sample_strobe,
    input  logic [ID_W-1:0]        trigger_id,
    input  logic [CYC_W-1:0]       trigger_cycle,
    input  logic [N_CH-1:0]        ch_data,
    input  logic                   flag_veto,
    input  logic                   flag_internal,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   veto_out,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            drop_count
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int DAT_B     = (N_CH + 7) / 8;
    localparam int PAY_B     = ID_W / 8 + CYC_W / 8 + 1 + DAT_B;
    localparam int PAY_W     = PAY_B * 8;
`ifdef TRIG_EVENT_BUFFER_CRC_EN
    localparam int CRC_B     = 1;
`else
    localparam int CRC_B     = 0;
`endif
    localparam int FRAME_LEN = PAY_B + CRC_B + 2;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int SH_W      = IDX_W + 3;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] PAY_LAST  = IDX_W'(PAY_B);
    localparam logic [IDX_W-1:0] PAY_TOP   = IDX_W'(PAY_B - 1);
    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_L      = LVL_W'(AF_LEVEL);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state_r;
    logic [PAY_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [LVL_W-1:0]   level_nxt_s;
    logic [15:0]        drop_r;
    logic               ovf_r;
    logic               veto_r;
    logic [7:0]         data_r;
    logic               valid_r;
    logic               last_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic               hs_s;
    logic               push_s;
    logic               pop_s;
    logic [DAT_B*8-1:0] ch_pad_s;
    logic [PAY_W-1:0]   wr_entry_s;
    logic [PAY_W-1:0]   head_s;
    logic [SH_W-1:0]    shamt_s;
    logic [7:0]         pay_byte_s;
    logic [7:0]         nxt_byte_s;

`ifdef TRIG_EVENT_BUFFER_CRC_EN
    localparam logic [IDX_W-1:0] CRC_IDX = IDX_W'(PAY_B + 1);

    logic [7:0] crc_r;
    logic [7:0] crc_nxt_s;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // Capture-side entry assembly and occupancy arithmetic; the full test uses the pre-edge level.
    always_comb begin
        ch_pad_s               = '0;
        ch_pad_s[N_CH-1:0]     = ch_data;
        wr_entry_s             = {trigger_id, trigger_cycle, flag_veto, flag_internal, ovf_r, 5'b00000, ch_pad_s};
        hs_s                   = valid_r && out_ready;
        push_s                 = sample_strobe && (level_r < DEPTH_L);
        pop_s                  = (state_r == SEND) && hs_s && (idx_r == LAST_IDX);
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LVL_W'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LVL_W'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Next frame byte: index 1..PAY_B maps onto payload byte idx_r, MSB first.
    always_comb begin
        head_s     = mem_r[rd_ptr_r];
        idx_nxt_s  = idx_r + IDX_W'(1);
        shamt_s    = {PAY_TOP - idx_r, 3'b000};
        pay_byte_s = 8'(head_s >> shamt_s);
`ifdef TRIG_EVENT_BUFFER_CRC_EN
        crc_nxt_s  = ((idx_r != '0) && (idx_r <= PAY_LAST)) ? crc8_update(crc_r, data_r) : crc_r;
`endif
        if (idx_nxt_s == LAST_IDX) begin
            nxt_byte_s = 8'h7D;
`ifdef TRIG_EVENT_BUFFER_CRC_EN
        end else if (idx_nxt_s == CRC_IDX) begin
            nxt_byte_s = crc_nxt_s;
`endif
        end else begin
            nxt_byte_s = pay_byte_s;
        end
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge sampling_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Write pointer, occupancy, veto, drop counter and the sticky overflow flag.
    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            level_r  <= '0;
            drop_r   <= 16'h0000;
            ovf_r    <= 1'b0;
            veto_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                ovf_r    <= 1'b0;
            end else if (sample_strobe) begin
                ovf_r <= 1'b1;
                if (drop_r != 16'hFFFF) begin
                    drop_r <= drop_r + 16'h0001;
                end
            end
            level_r <= level_nxt_s;
            veto_r  <= (level_nxt_s >= AF_L);
        end
    end

    // Reader FSM: walks the head entry byte by byte and frees it on the end-byte handshake.
    always_ff @(posedge sampling_clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            rd_ptr_r <= '0;
            idx_r    <= '0;
            data_r   <= 8'h00;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
`ifdef TRIG_EVENT_BUFFER_CRC_EN
            crc_r    <= 8'h00;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (level_r != '0) begin
                        state_r <= SEND;
                        idx_r   <= '0;
                        data_r  <= 8'h7E;
                        valid_r <= 1'b1;
                        last_r  <= 1'b0;
`ifdef TRIG_EVENT_BUFFER_CRC_EN
                        crc_r   <= 8'h00;
`endif
                    end
                end
                SEND: begin
                    if (pop_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                        idx_r    <= '0;
                        last_r   <= 1'b0;
`ifdef TRIG_EVENT_BUFFER_CRC_EN
                        crc_r    <= 8'h00;
`endif
                        // Another event waiting (including one written this edge): start it with no gap.
                        if (level_nxt_s != '0) begin
                            data_r  <= 8'h7E;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            data_r  <= 8'h00;
                            valid_r <= 1'b0;
                        end
                    end else if (hs_s) begin
                        idx_r  <= idx_nxt_s;
                        data_r <= nxt_byte_s;
                        last_r <= (idx_nxt_s == LAST_IDX);
`ifdef TRIG_EVENT_BUFFER_CRC_EN
                        crc_r  <= crc_nxt_s;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data   = data_r;
    assign out_valid  = valid_r;
    assign out_last   = last_r;
    assign veto_out   = veto_r;
    assign level      = level_r;
    assign drop_count = drop_r;

endmodule
